// File: rtl/child_seq_ctrl.sv
// child_seq_ctrl: launch/collect controller for a bank of NUM_CHILD child instances.
// Children are started either one after another (sequential) or all at once (parallel).
// Each child (seq) or the whole batch (par) gets at most TIMEOUT WAIT cycles to report done.
// Children that miss their window are flagged in err_mask_o.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start_i        launch request, sampled only in IDLE
//   mode_i         0 = sequential, 1 = parallel; captured on accepted start
//   child_start_o  one-cycle start pulse per child
//   child_done_i   done handshake per child (pulse or level)
//   busy_o         high from LAUNCH through FINISH
//   done_o         one-cycle completion pulse
//   err_mask_o     bit i set = child i timed out; held until the next accepted start
//   cur_idx_o      active child index in sequential mode, else 0
module child_seq_ctrl #(
  parameter int unsigned NUM_CHILD = 5,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = $clog2(TIMEOUT + 1),
  parameter int unsigned IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 mode_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NUM_CHILD-1:0] err_mask_o,
  output logic [IDX_W-1:0]     cur_idx_o
);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFinish} state_e;

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_CHILD - 1);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CHILD-1:0] pending_q, pending_d;
  logic [NUM_CHILD-1:0] err_q, err_d;

  logic                 resolve;
  logic [NUM_CHILD-1:0] pend_next;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    err_d     = err_q;
    resolve   = 1'b0;
    pend_next = pending_q & ~child_done_i;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mode_d  = mode_i;
          err_d   = '0;
          idx_d   = '0;
          state_d = StLaunch;
        end
      end

      // Done inputs are deliberately not looked at here.
      StLaunch: begin
        cnt_d = '0;
        if (mode_q) begin
          pending_d = {NUM_CHILD{1'b1}};
        end
        state_d = StWait;
      end

      StWait: begin
        if (!mode_q) begin
          // Done beats timeout when both land in the same cycle.
          if (child_done_i[idx_q]) begin
            resolve = 1'b1;
          end else if (cnt_q == CntMax) begin
            err_d[idx_q] = 1'b1;
            resolve      = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (resolve) begin
            if (idx_q == IdxLast) begin
              state_d = StFinish;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = StLaunch;
            end
          end
        end else begin
          pending_d = pend_next;
          if (pend_next == '0) begin
            state_d = StFinish;
          end else if (cnt_q == CntMax) begin
            err_d     = err_q | pend_next;
            pending_d = '0;
            state_d   = StFinish;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      StFinish: begin
        idx_d     = '0;
        pending_d = '0;
        state_d   = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    child_start_o = '0;
    if (state_q == StLaunch) begin
      child_start_o = mode_q ? {NUM_CHILD{1'b1}} : (NUM_CHILD'(1) << idx_q);
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StFinish);
  assign err_mask_o = err_q;
  assign cur_idx_o  = (state_q != StIdle && !mode_q) ? idx_q : '0;

endmodule
